// File: rtl/conv2_window_gen_pkg.sv
// Purpose: shared constants and types for the 5x5 convolution window generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package conv2_window_gen_pkg;

  localparam int MAP_W             = 12;
  localparam int K                 = 5;
  localparam int DW                = 12;
  localparam int LINE_DEPTH        = (K - 1) * MAP_W + K;
  localparam int WINDOWS_PER_FRAME = (MAP_W - K + 1) * (MAP_W - K + 1);
  localparam int CNT_W             = 4;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/conv2_line_buf.sv
// Purpose: single-channel raster shift line buffer exposing a registered KxK window.
// Latency: taps register one cycle after the pixel that is loaded with i_load.
// Backpressure: none; shifts only when i_shift, otherwise holds.
// Ports: clk/rst (sync, active-high), i_shift (accept pixel), i_load (capture window),
//        i_dat (pixel), o_taps (tap r*K+c, r=0 oldest row, c=0 leftmost column).
module conv2_line_buf #(
  parameter int MAP_W = conv2_window_gen_pkg::MAP_W,
  parameter int K     = conv2_window_gen_pkg::K,
  parameter int DW    = conv2_window_gen_pkg::DW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_shift,
  input  logic                    i_load,
  input  logic [DW-1:0]           i_dat,
  output logic [K*K-1:0][DW-1:0]  o_taps
);
  import conv2_window_gen_pkg::*;

  localparam int DEPTH = (K - 1) * MAP_W + K;

  // The newest entry of the DEPTH-long line is the pixel on i_dat itself, so
  // only DEPTH-1 entries need storage. w_nxt is the full line after the advance,
  // which lets the window containing the current pixel be registered this cycle.
  logic [DEPTH-2:0][DW-1:0] r_sr;
  logic [DEPTH-1:0][DW-1:0] w_nxt;
  logic [K*K-1:0][DW-1:0]   w_win;

  assign w_nxt = {r_sr, i_dat};

  // Entry d back in raster order sits (d / MAP_W) rows up and (d % MAP_W) columns left.
  always_comb begin
    w_win = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        w_win[r*K+c] = w_nxt[(K-1-r)*MAP_W + (K-1-c)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr   <= '0;
      o_taps <= '0;
    end else begin
      if (i_shift) r_sr <= w_nxt[DEPTH-2:0];
      if (i_load) o_taps <= w_win;
    end
  end

endmodule

// File: rtl/conv2_window_gen.sv
// Purpose: 3-channel 5x5 sliding-window generator over a square raster feature map.
// Latency: window valid_out_buf one cycle after the completing pixel is accepted.
// Backpressure: none; one pixel per cycle accepted, bubbles on valid_in=0 hold all state.
// Ports: clk, rst (sync, active-high), valid_in + data_in1..3 (raster pixels),
//        data_outC_N (tap N=r*5+c of channel C), valid_out_buf (window pulse),
//        frame_done (pulse with the last window of a frame).
module conv2_window_gen #(
  parameter int MAP_W = conv2_window_gen_pkg::MAP_W,
  parameter int K     = conv2_window_gen_pkg::K,
  parameter int DW    = conv2_window_gen_pkg::DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic signed [DW-1:0] data_in1,
  input  logic signed [DW-1:0] data_in2,
  input  logic signed [DW-1:0] data_in3,
  output logic signed [DW-1:0] data_out1_0,  data_out1_1,  data_out1_2,  data_out1_3,  data_out1_4,
  output logic signed [DW-1:0] data_out1_5,  data_out1_6,  data_out1_7,  data_out1_8,  data_out1_9,
  output logic signed [DW-1:0] data_out1_10, data_out1_11, data_out1_12, data_out1_13, data_out1_14,
  output logic signed [DW-1:0] data_out1_15, data_out1_16, data_out1_17, data_out1_18, data_out1_19,
  output logic signed [DW-1:0] data_out1_20, data_out1_21, data_out1_22, data_out1_23, data_out1_24,
  output logic signed [DW-1:0] data_out2_0,  data_out2_1,  data_out2_2,  data_out2_3,  data_out2_4,
  output logic signed [DW-1:0] data_out2_5,  data_out2_6,  data_out2_7,  data_out2_8,  data_out2_9,
  output logic signed [DW-1:0] data_out2_10, data_out2_11, data_out2_12, data_out2_13, data_out2_14,
  output logic signed [DW-1:0] data_out2_15, data_out2_16, data_out2_17, data_out2_18, data_out2_19,
  output logic signed [DW-1:0] data_out2_20, data_out2_21, data_out2_22, data_out2_23, data_out2_24,
  output logic signed [DW-1:0] data_out3_0,  data_out3_1,  data_out3_2,  data_out3_3,  data_out3_4,
  output logic signed [DW-1:0] data_out3_5,  data_out3_6,  data_out3_7,  data_out3_8,  data_out3_9,
  output logic signed [DW-1:0] data_out3_10, data_out3_11, data_out3_12, data_out3_13, data_out3_14,
  output logic signed [DW-1:0] data_out3_15, data_out3_16, data_out3_17, data_out3_18, data_out3_19,
  output logic signed [DW-1:0] data_out3_20, data_out3_21, data_out3_22, data_out3_23, data_out3_24,
  output logic                 valid_out_buf,
  output logic                 frame_done
);
  import conv2_window_gen_pkg::*;

  localparam cnt_t LAST  = cnt_t'(MAP_W - 1);
  localparam cnt_t FIRST = cnt_t'(K - 1);

  cnt_t r_row;
  cnt_t r_col;
  logic w_win;

  logic [K*K-1:0][DW-1:0] w_taps1;
  logic [K*K-1:0][DW-1:0] w_taps2;
  logic [K*K-1:0][DW-1:0] w_taps3;

  // A window is complete only once a full KxK block lies up-left of the current
  // pixel inside this row band, so windows never straddle rows or frames.
  assign w_win = valid_in && (r_row >= FIRST) && (r_col >= FIRST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row         <= '0;
      r_col         <= '0;
      valid_out_buf <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      valid_out_buf <= w_win;
      frame_done    <= w_win && (r_row == LAST) && (r_col == LAST);
      if (valid_in) begin
        if (r_col == LAST) begin
          r_col <= '0;
          r_row <= (r_row == LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  conv2_line_buf #(.MAP_W(MAP_W), .K(K), .DW(DW)) u_lb1 (
    .clk(clk), .rst(rst), .i_shift(valid_in), .i_load(w_win), .i_dat(data_in1), .o_taps(w_taps1)
  );
  conv2_line_buf #(.MAP_W(MAP_W), .K(K), .DW(DW)) u_lb2 (
    .clk(clk), .rst(rst), .i_shift(valid_in), .i_load(w_win), .i_dat(data_in2), .o_taps(w_taps2)
  );
  conv2_line_buf #(.MAP_W(MAP_W), .K(K), .DW(DW)) u_lb3 (
    .clk(clk), .rst(rst), .i_shift(valid_in), .i_load(w_win), .i_dat(data_in3), .o_taps(w_taps3)
  );

  assign data_out1_0  = w_taps1[0];  assign data_out1_1  = w_taps1[1];  assign data_out1_2  = w_taps1[2];
  assign data_out1_3  = w_taps1[3];  assign data_out1_4  = w_taps1[4];  assign data_out1_5  = w_taps1[5];
  assign data_out1_6  = w_taps1[6];  assign data_out1_7  = w_taps1[7];  assign data_out1_8  = w_taps1[8];
  assign data_out1_9  = w_taps1[9];  assign data_out1_10 = w_taps1[10]; assign data_out1_11 = w_taps1[11];
  assign data_out1_12 = w_taps1[12]; assign data_out1_13 = w_taps1[13]; assign data_out1_14 = w_taps1[14];
  assign data_out1_15 = w_taps1[15]; assign data_out1_16 = w_taps1[16]; assign data_out1_17 = w_taps1[17];
  assign data_out1_18 = w_taps1[18]; assign data_out1_19 = w_taps1[19]; assign data_out1_20 = w_taps1[20];
  assign data_out1_21 = w_taps1[21]; assign data_out1_22 = w_taps1[22]; assign data_out1_23 = w_taps1[23];
  assign data_out1_24 = w_taps1[24];

  assign data_out2_0  = w_taps2[0];  assign data_out2_1  = w_taps2[1];  assign data_out2_2  = w_taps2[2];
  assign data_out2_3  = w_taps2[3];  assign data_out2_4  = w_taps2[4];  assign data_out2_5  = w_taps2[5];
  assign data_out2_6  = w_taps2[6];  assign data_out2_7  = w_taps2[7];  assign data_out2_8  = w_taps2[8];
  assign data_out2_9  = w_taps2[9];  assign data_out2_10 = w_taps2[10]; assign data_out2_11 = w_taps2[11];
  assign data_out2_12 = w_taps2[12]; assign data_out2_13 = w_taps2[13]; assign data_out2_14 = w_taps2[14];
  assign data_out2_15 = w_taps2[15]; assign data_out2_16 = w_taps2[16]; assign data_out2_17 = w_taps2[17];
  assign data_out2_18 = w_taps2[18]; assign data_out2_19 = w_taps2[19]; assign data_out2_20 = w_taps2[20];
  assign data_out2_21 = w_taps2[21]; assign data_out2_22 = w_taps2[22]; assign data_out2_23 = w_taps2[23];
  assign data_out2_24 = w_taps2[24];

  assign data_out3_0  = w_taps3[0];  assign data_out3_1  = w_taps3[1];  assign data_out3_2  = w_taps3[2];
  assign data_out3_3  = w_taps3[3];  assign data_out3_4  = w_taps3[4];  assign data_out3_5  = w_taps3[5];
  assign data_out3_6  = w_taps3[6];  assign data_out3_7  = w_taps3[7];  assign data_out3_8  = w_taps3[8];
  assign data_out3_9  = w_taps3[9];  assign data_out3_10 = w_taps3[10]; assign data_out3_11 = w_taps3[11];
  assign data_out3_12 = w_taps3[12]; assign data_out3_13 = w_taps3[13]; assign data_out3_14 = w_taps3[14];
  assign data_out3_15 = w_taps3[15]; assign data_out3_16 = w_taps3[16]; assign data_out3_17 = w_taps3[17];
  assign data_out3_18 = w_taps3[18]; assign data_out3_19 = w_taps3[19]; assign data_out3_20 = w_taps3[20];
  assign data_out3_21 = w_taps3[21]; assign data_out3_22 = w_taps3[22]; assign data_out3_23 = w_taps3[23];
  assign data_out3_24 = w_taps3[24];

endmodule

// File: tb/tb_conv2_window_gen.sv
// Directed bench for conv2_window_gen: ramp frames, bubbles, back-to-back frames,
// mid-frame reset and signed extremes. Every output cycle is compared against a
// reference image kept by the bench plus hand-computed spot values.
module tb_conv2_window_gen;
  import conv2_window_gen_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_in = 1'b0;
  logic signed [11:0] data_in1 = '0, data_in2 = '0, data_in3 = '0;
  logic signed [11:0] o1 [25];
  logic signed [11:0] o2 [25];
  logic signed [11:0] o3 [25];
  logic valid_out_buf, frame_done;

  int checks = 0;
  int errors = 0;
  int pr = 0, pc = 0, pulses = 0;
  logic last_v;
  logic signed [11:0] img   [3][12][12];
  logic signed [11:0] exp_t [3][25];

  always #5 clk = ~clk;

  conv2_window_gen dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .data_out1_0(o1[0]),   .data_out1_1(o1[1]),   .data_out1_2(o1[2]),   .data_out1_3(o1[3]),   .data_out1_4(o1[4]),
    .data_out1_5(o1[5]),   .data_out1_6(o1[6]),   .data_out1_7(o1[7]),   .data_out1_8(o1[8]),   .data_out1_9(o1[9]),
    .data_out1_10(o1[10]), .data_out1_11(o1[11]), .data_out1_12(o1[12]), .data_out1_13(o1[13]), .data_out1_14(o1[14]),
    .data_out1_15(o1[15]), .data_out1_16(o1[16]), .data_out1_17(o1[17]), .data_out1_18(o1[18]), .data_out1_19(o1[19]),
    .data_out1_20(o1[20]), .data_out1_21(o1[21]), .data_out1_22(o1[22]), .data_out1_23(o1[23]), .data_out1_24(o1[24]),
    .data_out2_0(o2[0]),   .data_out2_1(o2[1]),   .data_out2_2(o2[2]),   .data_out2_3(o2[3]),   .data_out2_4(o2[4]),
    .data_out2_5(o2[5]),   .data_out2_6(o2[6]),   .data_out2_7(o2[7]),   .data_out2_8(o2[8]),   .data_out2_9(o2[9]),
    .data_out2_10(o2[10]), .data_out2_11(o2[11]), .data_out2_12(o2[12]), .data_out2_13(o2[13]), .data_out2_14(o2[14]),
    .data_out2_15(o2[15]), .data_out2_16(o2[16]), .data_out2_17(o2[17]), .data_out2_18(o2[18]), .data_out2_19(o2[19]),
    .data_out2_20(o2[20]), .data_out2_21(o2[21]), .data_out2_22(o2[22]), .data_out2_23(o2[23]), .data_out2_24(o2[24]),
    .data_out3_0(o3[0]),   .data_out3_1(o3[1]),   .data_out3_2(o3[2]),   .data_out3_3(o3[3]),   .data_out3_4(o3[4]),
    .data_out3_5(o3[5]),   .data_out3_6(o3[6]),   .data_out3_7(o3[7]),   .data_out3_8(o3[8]),   .data_out3_9(o3[9]),
    .data_out3_10(o3[10]), .data_out3_11(o3[11]), .data_out3_12(o3[12]), .data_out3_13(o3[13]), .data_out3_14(o3[14]),
    .data_out3_15(o3[15]), .data_out3_16(o3[16]), .data_out3_17(o3[17]), .data_out3_18(o3[18]), .data_out3_19(o3[19]),
    .data_out3_20(o3[20]), .data_out3_21(o3[21]), .data_out3_22(o3[22]), .data_out3_23(o3[23]), .data_out3_24(o3[24]),
    .valid_out_buf(valid_out_buf), .frame_done(frame_done)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
    end
  endtask

  // All 75 taps must equal the last expected window (or zero since reset).
  task automatic cmp_taps();
    for (int n = 0; n < 25; n++) begin
      chk12($sformatf("tap1_%0d", n), o1[n], exp_t[0][n]);
      chk12($sformatf("tap2_%0d", n), o2[n], exp_t[1][n]);
      chk12($sformatf("tap3_%0d", n), o3[n], exp_t[2][n]);
    end
  endtask

  task automatic clear_model();
    for (int ch = 0; ch < 3; ch++)
      for (int n = 0; n < 25; n++) exp_t[ch][n] = '0;
    pr = 0;
    pc = 0;
  endtask

  task automatic push(input logic signed [11:0] a, input logic signed [11:0] b, input logic signed [11:0] c);
    logic exp_f;
    data_in1 = a;
    data_in2 = b;
    data_in3 = c;
    valid_in = 1'b1;
    img[0][pr][pc] = a;
    img[1][pr][pc] = b;
    img[2][pr][pc] = c;
    last_v = (pr >= 4) && (pc >= 4);
    exp_f  = (pr == 11) && (pc == 11);
    if (last_v) begin
      pulses++;
      for (int n = 0; n < 25; n++)
        for (int ch = 0; ch < 3; ch++)
          exp_t[ch][n] = img[ch][pr - 4 + n / 5][pc - 4 + n % 5];
    end
    pc++;
    if (pc == 12) begin
      pc = 0;
      pr = (pr == 11) ? 0 : pr + 1;
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    chk("valid_out_buf", int'(valid_out_buf), int'(last_v));
    chk("frame_done", int'(frame_done), int'(exp_f));
    cmp_taps();
  endtask

  task automatic idle();
    valid_in = 1'b0;
    data_in1 = 12'sh5a5;
    data_in2 = 12'sh3c3;
    data_in3 = 12'sh0ff;
    last_v = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_valid_out_buf", int'(valid_out_buf), 0);
    chk("idle_frame_done", int'(frame_done), 0);
    cmp_taps();
  endtask

  // Ramp frame: ch1 = base + row*12 + col, ch2 = ch1 + 200, ch3 = -ch1.
  task automatic send_frame(input int base, input bit gaps, input string tag);
    int v;
    int cyc;
    pulses = 0;
    cyc = 0;
    for (int i = 0; i < 144; i++) begin
      if (gaps && (cyc % 3 == 2)) begin
        idle();
        cyc++;
      end
      v = base + i;
      push(12'(v), 12'(v + 200), 12'(-v));
      cyc++;
      if (last_v && pulses == 1) begin
        chk12({tag, "_p1_o1_0"},  o1[0],  12'(base));
        chk12({tag, "_p1_o1_4"},  o1[4],  12'(base + 4));
        chk12({tag, "_p1_o1_20"}, o1[20], 12'(base + 48));
        chk12({tag, "_p1_o1_24"}, o1[24], 12'(base + 52));
        chk12({tag, "_p1_o2_24"}, o2[24], 12'(base + 252));
        chk12({tag, "_p1_o3_24"}, o3[24], 12'(-(base + 52)));
      end
      if (last_v && pulses == 2) begin
        chk12({tag, "_p2_o1_0"},  o1[0],  12'(base + 1));
        chk12({tag, "_p2_o1_24"}, o1[24], 12'(base + 53));
      end
      if (last_v && pulses == 9) begin
        chk12({tag, "_p9_o1_0"},  o1[0],  12'(base + 12));
        chk12({tag, "_p9_o1_24"}, o1[24], 12'(base + 64));
      end
      if (last_v && pulses == 64) begin
        chk({tag, "_p64_frame_done"}, int'(frame_done), 1);
        chk12({tag, "_p64_o1_24"}, o1[24], 12'(base + 143));
      end
    end
    chk({tag, "_pulse_count"}, pulses, WINDOWS_PER_FRAME);
  endtask

  initial begin
    clear_model();
    rst = 1'b1;
    valid_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_out_buf", int'(valid_out_buf), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    cmp_taps();
    rst = 1'b0;
    valid_in = 1'b0;

    send_frame(0, 1'b0, "ramp");
    send_frame(0, 1'b1, "gaps");
    send_frame(1000, 1'b0, "frame2");

    // Partial frame (pixels 0..70), then one reset cycle with valid_in high.
    pulses = 0;
    for (int i = 0; i <= 70; i++) push(12'(i + 500), 12'(i + 700), 12'(-i));
    rst = 1'b1;
    valid_in = 1'b1;
    data_in1 = 12'sh123;
    @(posedge clk);
    #1;
    rst = 1'b0;
    valid_in = 1'b0;
    clear_model();
    chk("post_rst_valid_out_buf", int'(valid_out_buf), 0);
    chk("post_rst_frame_done", int'(frame_done), 0);
    cmp_taps();
    send_frame(0, 1'b0, "after_rst");

    // Signed extreme: every pixel of every channel is -2048.
    pulses = 0;
    for (int i = 0; i < 144; i++) push(-12'sd2048, -12'sd2048, -12'sd2048);
    chk("neg_pulse_count", pulses, 64);
    chk12("neg_o1_0", o1[0], 12'h800);
    chk12("neg_o2_12", o2[12], 12'h800);
    chk12("neg_o3_24", o3[24], 12'h800);
    chk("neg_sign", int'(o1[0] < 0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
